// File: rtl/resv_pkg.sv
// Shared types and helpers for the compacting reservation station: the stored
// entry layout, wakeup match and operand-readiness functions.
package resv_pkg;

  localparam int unsigned W_UOPS  = 6;
  localparam int unsigned W_RX_A  = 5;
  localparam int unsigned W_RX_D  = 32;
  localparam int unsigned W_IMM_D = 32;
  localparam int unsigned W_PC_D  = 32;
  localparam int unsigned W_PIP   = 2;  // room for up to four issue pipes

  typedef struct packed {
    logic              valid;
    logic [W_PIP-1:0]  pip;
    logic [1:0]        req;   // bit0: rs needed, bit1: rt needed
    logic [W_UOPS-1:0] uops;
    logic              rs_v;
    logic [W_RX_A-1:0] rs_a;
    logic [W_RX_D-1:0] rs_d;
    logic              rt_v;
    logic [W_RX_A-1:0] rt_a;
    logic [W_RX_D-1:0] rt_d;
    logic [W_IMM_D-1:0] imm_d;
    logic [W_PC_D-1:0] pc_d;
  } resv_entry_t;

  // A write-back port only fills an operand that is still waiting.
  function automatic logic wb_match(input logic              op_v,
                                    input logic [W_RX_A-1:0] op_a,
                                    input logic              wb_v,
                                    input logic [W_RX_A-1:0] wb_a);
    return !op_v && wb_v && (op_a == wb_a);
  endfunction

  function automatic logic entry_ready(input resv_entry_t e);
    return e.valid && (!e.req[0] || e.rs_v) && (!e.req[1] || e.rt_v);
  endfunction

endpackage

// File: rtl/resv_station_q_if.sv
// Dispatch, write-back and issue bundle of the reservation station. The
// master side is dispatch/execution, the slave side is the station itself.
interface resv_station_q_if #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned N_PIP   = 2,
  parameter int unsigned N_WB    = 2,
  parameter int unsigned W_uops  = 6,
  parameter int unsigned W_rx_a  = 5,
  parameter int unsigned W_rx_d  = 32,
  parameter int unsigned W_imm_d = 32,
  parameter int unsigned W_pc_d  = 32,
  parameter int unsigned W_cnt   = $clog2(DEPTH + 1),
  parameter int unsigned W_pip   = (N_PIP > 1) ? $clog2(N_PIP) : 1
);

  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [W_pip-1:0]           in_pip;
  logic [1:0]                 in_req;
  logic [W_uops-1:0]          in_uops;
  logic                       in_rs_v;
  logic                       in_rt_v;
  logic [W_rx_a-1:0]          in_rs_a;
  logic [W_rx_a-1:0]          in_rt_a;
  logic [W_rx_d-1:0]          in_rs_d;
  logic [W_rx_d-1:0]          in_rt_d;
  logic [W_imm_d-1:0]         in_imm_d;
  logic [W_pc_d-1:0]          in_pc_d;
  logic [N_WB-1:0]            wb_v;
  logic [N_WB*W_rx_a-1:0]     wb_a;
  logic [N_WB*W_rx_d-1:0]     wb_d;
  logic [N_PIP-1:0]           iss_valid;
  logic [N_PIP-1:0]           iss_ready;
  logic [N_PIP*W_uops-1:0]    iss_uops;
  logic [N_PIP*W_rx_d-1:0]    iss_rs_d;
  logic [N_PIP*W_rx_d-1:0]    iss_rt_d;
  logic [N_PIP*W_imm_d-1:0]   iss_imm_d;
  logic [N_PIP*W_pc_d-1:0]    iss_pc_d;
  logic [W_cnt-1:0]           count;
  logic                       empty;
  logic                       full;

  modport master (
    output flush, in_valid, in_pip, in_req, in_uops, in_rs_v, in_rt_v,
           in_rs_a, in_rt_a, in_rs_d, in_rt_d, in_imm_d, in_pc_d,
           wb_v, wb_a, wb_d, iss_ready,
    input  in_ready, iss_valid, iss_uops, iss_rs_d, iss_rt_d, iss_imm_d,
           iss_pc_d, count, empty, full
  );

  modport slave (
    input  flush, in_valid, in_pip, in_req, in_uops, in_rs_v, in_rt_v,
           in_rs_a, in_rt_a, in_rs_d, in_rt_d, in_imm_d, in_pc_d,
           wb_v, wb_a, wb_d, iss_ready,
    output in_ready, iss_valid, iss_uops, iss_rs_d, iss_rt_d, iss_imm_d,
           iss_pc_d, count, empty, full
  );

endinterface

// File: rtl/resv_wakeup.sv
// Operand wakeup: one source operand snooping N_WB write-back ports; the
// lowest-numbered matching port supplies the data.
module resv_wakeup
  import resv_pkg::*;
#(
  parameter int unsigned N_WB = 2,
  parameter int unsigned W_A  = W_RX_A,
  parameter int unsigned W_D  = W_RX_D
) (
  input  logic                op_v_i,
  input  logic [W_A-1:0]      op_a_i,
  input  logic [W_D-1:0]      op_d_i,
  input  logic [N_WB-1:0]     wb_v_i,
  input  logic [N_WB*W_A-1:0] wb_a_i,
  input  logic [N_WB*W_D-1:0] wb_d_i,
  output logic                op_v_o,
  output logic [W_D-1:0]      op_d_o
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves it unassigned, which would otherwise infer a latch.
    op_v_o = op_v_i;
    op_d_o = op_d_i;
    // Walk from the highest port down so the lowest matching port is applied last.
    for (int k = N_WB - 1; k >= 0; k--) begin
      if (wb_match(op_v_i, op_a_i, wb_v_i[k], wb_a_i[k*W_A +: W_A])) begin
        op_v_o = 1'b1;
        op_d_o = wb_d_i[k*W_D +: W_D];
      end
    end
  end

endmodule

// File: rtl/resv_station_q.sv
// Compacting reservation-station queue: in-order storage with multi-port
// operand wakeup, oldest-ready select per pipe and same-edge compaction.
module resv_station_q
  import resv_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned N_PIP   = 2,
  parameter int unsigned N_WB    = 2,
  parameter int unsigned W_uops  = W_UOPS,
  parameter int unsigned W_rx_a  = W_RX_A,
  parameter int unsigned W_rx_d  = W_RX_D,
  parameter int unsigned W_imm_d = W_IMM_D,
  parameter int unsigned W_pc_d  = W_PC_D
) (
  input  logic            clk,
  input  logic            clear,
  resv_station_q_if.slave bus
);

  localparam int unsigned W_cnt = $clog2(DEPTH + 1);
  localparam int unsigned W_idx = $clog2(DEPTH);

  resv_entry_t       ent_q   [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [W_cnt-1:0]  count_q;
  logic [W_cnt-1:0]  count_d;

  resv_entry_t       ent     [DEPTH];
  resv_entry_t       woke    [DEPTH];
  resv_entry_t       ent_d   [DEPTH];
  resv_entry_t       new_woke;

  logic [DEPTH-1:0]  rs_v_w;
  logic [DEPTH-1:0]  rt_v_w;
  logic [W_rx_d-1:0] rs_d_w  [DEPTH];
  logic [W_rx_d-1:0] rt_d_w  [DEPTH];
  logic              new_rs_v;
  logic              new_rt_v;
  logic [W_rx_d-1:0] new_rs_d;
  logic [W_rx_d-1:0] new_rt_d;

  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  rmv;
  logic [N_PIP-1:0]  sel_found;
  logic [W_idx-1:0]  sel_idx [N_PIP];
  logic [W_cnt-1:0]  rm_total;
  logic [W_idx-1:0]  dst;
  logic [W_idx-1:0]  ins_idx;
  logic              in_ready;
  logic              accept;

  assign in_ready  = (count_q != W_cnt'(DEPTH));
  assign accept    = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;
  assign bus.count = count_q;
  assign bus.empty = (count_q == '0);
  assign bus.full  = !in_ready;

  // Valid bits live in a reset register; the payload array carries the rest.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      ent[e]       = ent_q[e];
      ent[e].valid = valid_q[e];
      rdy[e]       = entry_ready(ent[e]);
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_wake
    resv_wakeup #(.N_WB(N_WB), .W_A(W_rx_a), .W_D(W_rx_d)) u_rs (
      .op_v_i (ent[e].rs_v), .op_a_i (ent[e].rs_a), .op_d_i (ent[e].rs_d),
      .wb_v_i (bus.wb_v),    .wb_a_i (bus.wb_a),    .wb_d_i (bus.wb_d),
      .op_v_o (rs_v_w[e]),   .op_d_o (rs_d_w[e])
    );
    resv_wakeup #(.N_WB(N_WB), .W_A(W_rx_a), .W_D(W_rx_d)) u_rt (
      .op_v_i (ent[e].rt_v), .op_a_i (ent[e].rt_a), .op_d_i (ent[e].rt_d),
      .wb_v_i (bus.wb_v),    .wb_a_i (bus.wb_a),    .wb_d_i (bus.wb_d),
      .op_v_o (rt_v_w[e]),   .op_d_o (rt_d_w[e])
    );
  end

  resv_wakeup #(.N_WB(N_WB), .W_A(W_rx_a), .W_D(W_rx_d)) u_new_rs (
    .op_v_i (bus.in_rs_v), .op_a_i (bus.in_rs_a), .op_d_i (bus.in_rs_d),
    .wb_v_i (bus.wb_v),    .wb_a_i (bus.wb_a),    .wb_d_i (bus.wb_d),
    .op_v_o (new_rs_v),    .op_d_o (new_rs_d)
  );
  resv_wakeup #(.N_WB(N_WB), .W_A(W_rx_a), .W_D(W_rx_d)) u_new_rt (
    .op_v_i (bus.in_rt_v), .op_a_i (bus.in_rt_a), .op_d_i (bus.in_rt_d),
    .wb_v_i (bus.wb_v),    .wb_a_i (bus.wb_a),    .wb_d_i (bus.wb_d),
    .op_v_o (new_rt_v),    .op_d_o (new_rt_d)
  );

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      woke[e]      = ent[e];
      woke[e].rs_v = rs_v_w[e];
      woke[e].rs_d = rs_d_w[e];
      woke[e].rt_v = rt_v_w[e];
      woke[e].rt_d = rt_d_w[e];
    end
    new_woke.valid = 1'b1;
    new_woke.pip   = W_PIP'(bus.in_pip);
    new_woke.req   = bus.in_req;
    new_woke.uops  = bus.in_uops;
    new_woke.rs_v  = new_rs_v;
    new_woke.rs_a  = bus.in_rs_a;
    new_woke.rs_d  = new_rs_d;
    new_woke.rt_v  = new_rt_v;
    new_woke.rt_a  = bus.in_rt_a;
    new_woke.rt_d  = new_rt_d;
    new_woke.imm_d = bus.in_imm_d;
    new_woke.pc_d  = bus.in_pc_d;
  end

  // Oldest ready entry per pipe: scan from the top so the lowest index sticks.
  always_comb begin
    sel_found = '0;
    for (int p = 0; p < N_PIP; p++) begin
      sel_idx[p] = '0;
      for (int e = DEPTH - 1; e >= 0; e--) begin
        if (rdy[e] && (ent[e].pip == W_PIP'(p))) begin
          sel_found[p] = 1'b1;
          sel_idx[p]   = W_idx'(e);
        end
      end
    end
  end

  always_comb begin
    rmv = '0;
    for (int p = 0; p < N_PIP; p++) begin
      if (sel_found[p] && bus.iss_ready[p]) rmv[sel_idx[p]] = 1'b1;
    end
  end

  always_comb begin
    bus.iss_valid = sel_found;
    bus.iss_uops  = '0;
    bus.iss_rs_d  = '0;
    bus.iss_rt_d  = '0;
    bus.iss_imm_d = '0;
    bus.iss_pc_d  = '0;
    for (int p = 0; p < N_PIP; p++) begin
      bus.iss_uops [p*W_uops  +: W_uops ] = ent[sel_idx[p]].uops;
      bus.iss_rs_d [p*W_rx_d  +: W_rx_d ] = ent[sel_idx[p]].rs_d;
      bus.iss_rt_d [p*W_rx_d  +: W_rx_d ] = ent[sel_idx[p]].rt_d;
      bus.iss_imm_d[p*W_imm_d +: W_imm_d] = ent[sel_idx[p]].imm_d;
      bus.iss_pc_d [p*W_pc_d  +: W_pc_d ] = ent[sel_idx[p]].pc_d;
    end
  end

  // Each survivor slides down by the number of removals below it; the new
  // entry lands right after the last survivor.
  always_comb begin
    rm_total = '0;
    dst      = '0;
    for (int e = 0; e < DEPTH; e++) begin
      ent_d[e]       = ent[e];
      ent_d[e].valid = 1'b0;
    end
    for (int e = 0; e < DEPTH; e++) begin
      if (rmv[e]) begin
        rm_total = rm_total + W_cnt'(1);
      end else if (ent[e].valid) begin
        dst        = W_idx'(e) - W_idx'(rm_total);
        ent_d[dst] = woke[e];
      end
    end
    ins_idx = W_idx'(count_q - rm_total);
    if (accept && !bus.flush) ent_d[ins_idx] = new_woke;
    count_d = count_q - rm_total + W_cnt'(accept);
    if (bus.flush) begin
      count_d = '0;
      for (int e = 0; e < DEPTH; e++) ent_d[e].valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_q <= '0;
      valid_q <= '0;
    end else begin
      count_q <= count_d;
      for (int e = 0; e < DEPTH; e++) valid_q[e] <= ent_d[e].valid;
    end
  end

  // NOTE: payload storage has no reset; the valid bits alone decide whether a
  // slot means anything, so resetting wide data would only cost routing.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) ent_q[e] <= ent_d[e];
  end

endmodule

// File: tb/tb_resv_station_q.sv
// Scoreboard bench for resv_station_q: expected issue payloads are queued per
// pipe as stimulus is driven and compared as the station issues them.
module tb_resv_station_q;

  localparam int DEPTH = 8;
  localparam int N_PIP = 2;
  localparam int N_WB  = 2;

  typedef struct packed {
    logic [5:0]  uops;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm_d;
    logic [31:0] pc_d;
  } rec_t;

  logic clk = 1'b0;
  logic clear;
  int   errors = 0;
  int   checks = 0;
  rec_t sb [N_PIP][$];

  resv_station_q_if #(.DEPTH(DEPTH), .N_PIP(N_PIP), .N_WB(N_WB)) bus ();

  resv_station_q #(.DEPTH(DEPTH), .N_PIP(N_PIP), .N_WB(N_WB)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rec_t mk(input int id, input logic [31:0] rs, input logic [31:0] rt);
    rec_t r;
    r.uops  = 6'(id);
    r.rs_d  = rs;
    r.rt_d  = rt;
    r.imm_d = 32'h1000 + 32'(id);
    r.pc_d  = 32'h4000 + 32'(id * 4);
    return r;
  endfunction

  function automatic rec_t obs(input int p);
    rec_t r;
    r.uops  = bus.iss_uops[p*6 +: 6];
    r.rs_d  = bus.iss_rs_d[p*32 +: 32];
    r.rt_d  = bus.iss_rt_d[p*32 +: 32];
    r.imm_d = bus.iss_imm_d[p*32 +: 32];
    r.pc_d  = bus.iss_pc_d[p*32 +: 32];
    return r;
  endfunction

  task automatic drive_in(input logic pip, input logic [1:0] req,
                          input logic rs_v, input logic [4:0] rs_a, input logic [31:0] rs_d,
                          input logic rt_v, input logic [4:0] rt_a, input logic [31:0] rt_d,
                          input int id);
    bus.in_valid = 1'b1;
    bus.in_pip   = pip;
    bus.in_req   = req;
    bus.in_uops  = 6'(id);
    bus.in_rs_v  = rs_v;
    bus.in_rs_a  = rs_a;
    bus.in_rs_d  = rs_d;
    bus.in_rt_v  = rt_v;
    bus.in_rt_a  = rt_a;
    bus.in_rt_d  = rt_d;
    bus.in_imm_d = 32'h1000 + 32'(id);
    bus.in_pc_d  = 32'h4000 + 32'(id * 4);
  endtask

  task automatic set_wb(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
    bus.wb_v = v;
    bus.wb_a = {a1, a0};
    bus.wb_d = {d1, d0};
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.wb_v     = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
    checks++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL reset_iss_valid: got %b exp 00", bus.iss_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b exp 10", bus.empty, bus.full); end
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_in_order();
    rec_t e;
    bus.iss_ready = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      drive_in(1'b0, 2'b11, 1'b1, 5'd1, 32'h100 + 32'(i), 1'b1, 5'd2, 32'h200 + 32'(i), i);
      sb[0].push_back(mk(i, 32'h100 + 32'(i), 32'h200 + 32'(i)));
      step();
    end
    idle();
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL order_count_full: got %0d exp 3", bus.count); end
    bus.iss_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      e = sb[0].pop_front();
      checks++;
      if (bus.iss_valid[0] !== 1'b1 || obs(0) !== e) begin
        errors++; $display("FAIL order_issue%0d: got v=%b %h exp v=1 %h", i, bus.iss_valid[0], obs(0), e);
      end
      step();
      checks++; if (bus.count !== 4'(2 - i)) begin errors++; $display("FAIL order_count%0d: got %0d exp %0d", i, bus.count, 2 - i); end
    end
    checks++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL order_drained: got %b exp 00", bus.iss_valid); end
    bus.iss_ready = 2'b00;
  endtask

  task automatic test_full_wakeup();
    rec_t e;
    int   cyc;
    for (int i = 20; i < 28; i++) begin
      drive_in(1'b0, 2'b01, 1'b0, 5'd5, 32'h0, 1'b1, 5'd6, 32'h300 + 32'(i), i);
      sb[0].push_back(mk(i, 32'hDEAD, 32'h300 + 32'(i)));
      step();
    end
    idle();
    checks++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin errors++; $display("FAIL full_flag: got full=%b count=%0d exp full=1 count=8", bus.full, bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b exp 0", bus.in_ready); end
    checks++; if (bus.iss_valid[0] !== 1'b0) begin errors++; $display("FAIL full_waiting: got %b exp 0", bus.iss_valid[0]); end
    set_wb(2'b01, 5'd5, 32'hDEAD, 5'd0, 32'h0);
    step();
    idle();
    e = sb[0].pop_front();
    checks++;
    if (bus.iss_valid[0] !== 1'b1 || obs(0) !== e) begin
      errors++; $display("FAIL full_wakeup_issue: got v=%b %h exp v=1 %h", bus.iss_valid[0], obs(0), e);
    end
    // Offer an insert while full with an issue in flight: it must be refused.
    bus.iss_ready = 2'b01;
    drive_in(1'b0, 2'b00, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 28);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_no_replace: got %b exp 0", bus.in_ready); end
    step();
    idle();
    checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL full_count_after: got %0d exp 7", bus.count); end
    cyc = 0;
    while (sb[0].size() > 0 && cyc < 20) begin
      if (bus.iss_valid[0] === 1'b1) begin
        e = sb[0].pop_front();
        checks++;
        if (obs(0) !== e) begin errors++; $display("FAIL full_drain: got %h exp %h", obs(0), e); end
      end
      step();
      cyc++;
    end
    checks++; if (sb[0].size() != 0) begin errors++; $display("FAIL full_drain_timeout: got %0d left exp 0", sb[0].size()); sb[0].delete(); end
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty: got count=%0d exp 0", bus.count); end
    bus.iss_ready = 2'b00;
  endtask

  task automatic test_insert_wakeup();
    rec_t e;
    bus.iss_ready = 2'b10;
    drive_in(1'b1, 2'b10, 1'b1, 5'd1, 32'h55, 1'b0, 5'd7, 32'h0, 30);
    set_wb(2'b11, 5'd3, 32'h9999, 5'd7, 32'h1234);
    sb[1].push_back(mk(30, 32'h55, 32'h1234));
    step();
    idle();
    e = sb[1].pop_front();
    checks++;
    if (bus.iss_valid[1] !== 1'b1 || obs(1) !== e) begin
      errors++; $display("FAIL insert_wakeup: got v=%b %h exp v=1 %h", bus.iss_valid[1], obs(1), e);
    end
    step();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL insert_wakeup_count: got %0d exp 0", bus.count); end
    bus.iss_ready = 2'b00;
  endtask

  task automatic test_wb_priority();
    rec_t e;
    drive_in(1'b0, 2'b01, 1'b0, 5'd9, 32'h0, 1'b1, 5'd4, 32'h350, 50);
    sb[0].push_back(mk(50, 32'hA, 32'h350));
    step();
    idle();
    checks++; if (bus.iss_valid[0] !== 1'b0) begin errors++; $display("FAIL prio_waiting: got %b exp 0", bus.iss_valid[0]); end
    set_wb(2'b11, 5'd9, 32'hA, 5'd9, 32'hB);
    step();
    // A later write-back to the same register must not disturb the captured value.
    set_wb(2'b01, 5'd9, 32'hC, 5'd0, 32'h0);
    checks++; if (bus.iss_valid[0] !== 1'b1) begin errors++; $display("FAIL prio_woken: got %b exp 1", bus.iss_valid[0]); end
    step();
    idle();
    e = sb[0].pop_front();
    checks++; if (obs(0) !== e) begin errors++; $display("FAIL prio_capture: got %h exp %h", obs(0), e); end
    bus.iss_ready = 2'b01;
    step();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL prio_count: got %0d exp 0", bus.count); end
    bus.iss_ready = 2'b00;
  endtask

  task automatic test_compaction();
    rec_t e;
    int   cyc;
    drive_in(1'b0, 2'b01, 1'b0, 5'd20, 32'h0,   1'b1, 5'd0,  32'h310, 10); step();
    drive_in(1'b0, 2'b00, 1'b1, 5'd0,  32'h111, 1'b1, 5'd0,  32'h311, 11); step();
    drive_in(1'b1, 2'b10, 1'b1, 5'd0,  32'h112, 1'b0, 5'd21, 32'h0,   12); step();
    drive_in(1'b1, 2'b00, 1'b1, 5'd0,  32'h113, 1'b1, 5'd0,  32'h313, 13); step();
    drive_in(1'b0, 2'b01, 1'b0, 5'd22, 32'h0,   1'b1, 5'd0,  32'h314, 14); step();
    idle();
    sb[0].push_back(mk(11, 32'h111, 32'h311));
    sb[1].push_back(mk(13, 32'h113, 32'h313));
    for (int p = 0; p < 2; p++) begin
      e = sb[p].pop_front();
      checks++;
      if (bus.iss_valid[p] !== 1'b1 || obs(p) !== e) begin
        errors++; $display("FAIL compact_sel%0d: got v=%b %h exp v=1 %h", p, bus.iss_valid[p], obs(p), e);
      end
    end
    // Both pipes issue while a new entry is accepted at the same edge.
    bus.iss_ready = 2'b11;
    drive_in(1'b0, 2'b01, 1'b0, 5'd23, 32'h0, 1'b1, 5'd0, 32'h315, 15);
    step();
    idle();
    bus.iss_ready = 2'b00;
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL compact_count: got %0d exp 4", bus.count); end
    checks++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL compact_none_ready: got %b exp 00", bus.iss_valid); end
    set_wb(2'b11, 5'd20, 32'h200, 5'd22, 32'h222);
    step();
    set_wb(2'b11, 5'd23, 32'h233, 5'd21, 32'h211);
    step();
    idle();
    sb[0].push_back(mk(10, 32'h200, 32'h310));
    sb[0].push_back(mk(14, 32'h222, 32'h314));
    sb[0].push_back(mk(15, 32'h233, 32'h315));
    sb[1].push_back(mk(12, 32'h112, 32'h211));
    bus.iss_ready = 2'b11;
    cyc = 0;
    while ((sb[0].size() + sb[1].size()) > 0 && cyc < 12) begin
      for (int p = 0; p < 2; p++) begin
        if (bus.iss_valid[p] === 1'b1) begin
          checks++;
          if (sb[p].size() == 0) begin
            errors++; $display("FAIL compact_extra%0d: got %h exp no issue", p, obs(p));
          end else begin
            e = sb[p].pop_front();
            if (obs(p) !== e) begin errors++; $display("FAIL compact_order%0d: got %h exp %h", p, obs(p), e); end
          end
        end
      end
      step();
      cyc++;
    end
    checks++;
    if ((sb[0].size() + sb[1].size()) != 0) begin
      errors++; $display("FAIL compact_timeout: got %0d left exp 0", sb[0].size() + sb[1].size());
      sb[0].delete(); sb[1].delete();
    end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL compact_empty: got %0d exp 0", bus.count); end
    bus.iss_ready = 2'b00;
  endtask

  task automatic test_flush();
    rec_t e;
    for (int i = 40; i < 44; i++) begin
      drive_in(1'b1, 2'b00, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, i);
      step();
    end
    idle();
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL flush_pre_count: got %0d exp 4", bus.count); end
    bus.flush = 1'b1;
    drive_in(1'b1, 2'b00, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 44);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b exp 1", bus.in_ready); end
    step();
    bus.flush = 1'b0;
    idle();
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL flush_count: got %0d exp 0", bus.count); end
    checks++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL flush_iss_valid: got %b exp 00", bus.iss_valid); end
    bus.iss_ready = 2'b10;
    drive_in(1'b1, 2'b11, 1'b1, 5'd0, 32'h145, 1'b1, 5'd0, 32'h245, 45);
    sb[1].push_back(mk(45, 32'h145, 32'h245));
    step();
    idle();
    e = sb[1].pop_front();
    checks++;
    if (bus.iss_valid[1] !== 1'b1 || obs(1) !== e) begin
      errors++; $display("FAIL flush_reuse: got v=%b %h exp v=1 %h", bus.iss_valid[1], obs(1), e);
    end
    step();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_reuse_count: got %0d exp 0", bus.count); end
    bus.iss_ready = 2'b00;
  endtask

  task automatic test_clear_async();
    for (int i = 60; i < 65; i++) begin
      drive_in(1'b0, 2'b00, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, i);
      step();
    end
    idle();
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL clear_pre_count: got %0d exp 5", bus.count); end
    #2;
    clear = 1'b1;
    #1;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL clear_async_count: got %0d exp 0", bus.count); end
    checks++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL clear_async_iss: got %b exp 00", bus.iss_valid); end
    checks++; if (bus.in_ready !== 1'b1 || bus.empty !== 1'b1) begin errors++; $display("FAIL clear_async_flags: got rdy=%b empty=%b exp 1 1", bus.in_ready, bus.empty); end
    step();
    clear = 1'b0;
    step();
    checks++; if (bus.count !== 4'd0 || bus.iss_valid !== 2'b00) begin errors++; $display("FAIL clear_release: got count=%0d iss=%b exp 0 00", bus.count, bus.iss_valid); end
  endtask

  initial begin
    clear         = 1'b1;
    bus.flush     = 1'b0;
    bus.iss_ready = '0;
    bus.in_pip    = '0;
    bus.in_req    = '0;
    bus.in_uops   = '0;
    bus.in_rs_v   = 1'b0;
    bus.in_rt_v   = 1'b0;
    bus.in_rs_a   = '0;
    bus.in_rt_a   = '0;
    bus.in_rs_d   = '0;
    bus.in_rt_d   = '0;
    bus.in_imm_d  = '0;
    bus.in_pc_d   = '0;
    bus.wb_a      = '0;
    bus.wb_d      = '0;
    idle();

    test_reset();
    test_in_order();
    test_full_wakeup();
    test_insert_wakeup();
    test_wb_priority();
    test_compaction();
    test_flush();
    test_clear_async();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
